// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-drain UART transmitter: state encoding and line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } uart_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam logic START_LEVEL     = 1'b0;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count as a one-cycle tick.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear || cnt == TERM) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == TERM);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a registered-read FIFO and serializes each byte as an 8N1 frame (optional even parity).
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tx_enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_read_en,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  uart_state_t      state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nx;
  logic [BW-1:0]    bit_cnt;
  logic             parity_bit;
  logic             tick;
  logic             baud_clear;
  logic             can_pop;

  // Handshake: a pop is issued only when tx_enable && !fifo_empty are seen at the edge that
  // enters POP; the FIFO presents data_out one cycle later, which LOAD captures unconditionally.
  assign can_pop      = tx_enable && !fifo_empty;
  assign shreg_nx     = shreg >> 1;
  assign baud_clear   = (state == IDLE) || (state == POP) || (state == LOAD);
  assign fifo_read_en = (state == POP);
  assign busy         = (state != IDLE);
  assign frame_done   = (state == STOP) && tick;

  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (baud_clear),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      parity_bit <= 1'b0;
      tx         <= UART_IDLE_LEVEL;
    end else begin
      case (state)
        IDLE: begin
          tx <= UART_IDLE_LEVEL;
          if (can_pop) state <= POP;
        end
        POP: begin
          tx    <= UART_IDLE_LEVEL;
          state <= LOAD;
        end
        LOAD: begin
          shreg      <= fifo_data;
          parity_bit <= ^fifo_data;
          bit_cnt    <= '0;
          tx         <= START_LEVEL;
          state      <= START;
        end
        START: begin
          if (tick) begin
            tx    <= shreg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            shreg <= shreg_nx;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                tx    <= parity_bit;
                state <= PARITY;
              end else begin
                tx    <= UART_IDLE_LEVEL;
                state <= STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shreg_nx[0];
            end
          end
        end
        PARITY: begin
          if (tick) begin
            tx    <= UART_IDLE_LEVEL;
            state <= STOP;
          end
        end
        STOP: begin
          tx <= UART_IDLE_LEVEL;
          // Back-to-back frames re-enter POP directly, leaving POP+LOAD as the only gap.
          if (tick) state <= can_pop ? POP : IDLE;
        end
        default: begin
          tx    <= UART_IDLE_LEVEL;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench: two transmitters (no parity / even parity), each fed by a FIFO model.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic clk;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int P = g;
    localparam int L = (2 + 8 + P) * CPB;

    logic       tx, busy, fd, rd_en, fempty, en;
    logic [7:0] fdata;
    logic [7:0] fq[$];
    logic [7:0] exp_q[$];
    int         pops = 0;

    assign fempty = (fq.size() == 0);

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(P)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .tx_enable    (en),
      .fifo_empty   (fempty),
      .fifo_data    (fdata),
      .fifo_read_en (rd_en),
      .tx           (tx),
      .busy         (busy),
      .frame_done   (fd)
    );

    // Registered-read FIFO model: data_out updates on the edge that samples read_en.
    always @(posedge clk) begin
      if (rd_en) begin
        check($sformatf("underflow[%0d]", g), 32'(fempty), 32'd0);
        if (fq.size() > 0) fdata <= fq.pop_front();
        pops++;
      end
    end

    // Line monitor: decodes each frame at mid-bit and scores it against exp_q.
    initial begin : mon
      logic        start_seen, aborted, busy_ok;
      logic [15:0] bits;
      logic [7:0]  e;
      int          n, fd_cnt, fd_last;
      start_seen = 1'b0;
      forever begin
        if (!start_seen) begin
          @(negedge clk);
          while (!(reset_n === 1'b1 && tx === 1'b0)) @(negedge clk);
        end
        start_seen = 1'b0;
        aborted = 1'b0;
        busy_ok = 1'b1;
        bits = '0;
        fd_cnt = 0;
        fd_last = 0;
        for (int c = 0; c < L; c++) begin
          if (c > 0) @(negedge clk);
          if (!reset_n) begin
            aborted = 1'b1;
            break;
          end
          if (c % CPB == CPB / 2) bits[c / CPB] = tx;
          if (!busy) busy_ok = 1'b0;
          if (fd) begin
            fd_cnt++;
            if (c == L - 1) fd_last = 1;
          end
        end
        if (aborted) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          wait (reset_n === 1'b1);
          continue;
        end
        check($sformatf("start_bit[%0d]", g), 32'(bits[0]), 32'd0);
        check($sformatf("stop_bit[%0d]", g), 32'(bits[L / CPB - 1]), 32'd1);
        check($sformatf("busy_in_frame[%0d]", g), 32'(busy_ok), 32'd1);
        check($sformatf("frame_done_count[%0d]", g), 32'(fd_cnt), 32'd1);
        check($sformatf("frame_done_last[%0d]", g), 32'(fd_last), 32'd1);
        if (exp_q.size() == 0) begin
          check($sformatf("unexpected_frame[%0d]", g), 32'(bits[8:1]), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("frame_data[%0d]", g), 32'(bits[8:1]), 32'(e));
          if (P != 0) check($sformatf("parity_bit[%0d]", g), 32'(bits[9]), 32'(^e));
        end
        n = 0;
        for (int k = 0; k < 16; k++) begin
          @(negedge clk);
          if (!reset_n || !busy) break;
          if (tx === 1'b0) begin
            start_seen = 1'b1;
            break;
          end
          n++;
        end
        if (start_seen) check($sformatf("b2b_gap[%0d]", g), 32'(n), 32'd2);
      end
    end
  end

  function automatic logic busy_of(input int g);
    return (g == 0) ? u[0].busy : u[1].busy;
  endfunction

  function automatic logic tx_of(input int g);
    return (g == 0) ? u[0].tx : u[1].tx;
  endfunction

  task automatic push_byte(input int g, input logic [7:0] b);
    if (g == 0) begin
      u[0].fq.push_back(b);
      u[0].exp_q.push_back(b);
    end else begin
      u[1].fq.push_back(b);
      u[1].exp_q.push_back(b);
    end
  endtask

  task automatic wait_idle(input int g, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy_of(g)) return;
    end
    check($sformatf("idle_timeout[%0d]", g), 32'd1, 32'd0);
  endtask

  task automatic wait_tx_low(input int g, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (tx_of(g) == 1'b0) return;
    end
    check($sformatf("tx_low_timeout[%0d]", g), 32'd1, 32'd0);
  endtask

  initial begin : main
    int base, fdc;
    logic busy_drop;

    reset_n = 1'b0;
    u[0].en = 1'b0;
    u[1].en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx0", 32'(u[0].tx), 32'd1);
    check("rst_busy0", 32'(u[0].busy), 32'd0);
    check("rst_rd0", 32'(u[0].rd_en), 32'd0);
    check("rst_fd0", 32'(u[0].fd), 32'd0);
    check("rst_tx1", 32'(u[1].tx), 32'd1);
    check("rst_busy1", 32'(u[1].busy), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Flow control: byte waits while disabled, pops on enable, disable mid-frame stops the drain.
    push_byte(0, 8'h5A);
    repeat (12) @(negedge clk);
    check("flow_no_pop", 32'(u[0].pops), 32'd0);
    check("flow_tx_idle", 32'(u[0].tx), 32'd1);
    check("flow_not_busy", 32'(u[0].busy), 32'd0);
    u[0].en = 1'b1;
    @(negedge clk);
    check("flow_pop_strobe", 32'(u[0].rd_en), 32'd1);
    wait_tx_low(0, 20);
    repeat (8) @(negedge clk);
    u[0].en = 1'b0;
    push_byte(0, 8'h77);
    wait_idle(0, 200);
    check("flow_one_pop", 32'(u[0].pops), 32'd1);
    repeat (10) @(negedge clk);
    check("flow_still_one_pop", 32'(u[0].pops), 32'd1);
    check("flow_byte_kept", 32'(u[0].fq.size()), 32'd1);
    u[0].en = 1'b1;
    @(negedge clk);
    wait_idle(0, 200);
    check("flow_resume_pop", 32'(u[0].pops), 32'd2);

    // Single byte.
    base = u[0].pops;
    push_byte(0, 8'hA5);
    wait_idle(0, 200);
    check("single_pop", 32'(u[0].pops - base), 32'd1);

    // Back-to-back frames with busy held high across them.
    base = u[0].pops;
    u[0].en = 1'b0;
    push_byte(0, 8'hA1);
    push_byte(0, 8'hB2);
    push_byte(0, 8'hC3);
    u[0].en = 1'b1;
    fdc = 0;
    busy_drop = 1'b0;
    for (int k = 0; k < 400 && fdc < 3; k++) begin
      @(negedge clk);
      if (!u[0].busy) busy_drop = 1'b1;
      if (u[0].fd) fdc++;
    end
    check("b2b_frames", 32'(fdc), 32'd3);
    check("b2b_busy_held", 32'(busy_drop), 32'd0);
    @(negedge clk);
    check("b2b_idle_after", 32'(u[0].busy), 32'd0);
    check("b2b_pops", 32'(u[0].pops - base), 32'd3);

    // Full drain of 16 bytes.
    base = u[0].pops;
    u[0].en = 1'b0;
    for (int i = 0; i < 16; i++) push_byte(0, 8'(i));
    u[0].en = 1'b1;
    @(negedge clk);
    wait_idle(0, 16 * 60);
    check("drain_pops", 32'(u[0].pops - base), 32'd16);
    check("drain_empty", 32'(u[0].fempty), 32'd1);
    repeat (20) @(negedge clk);
    check("drain_no_extra_pop", 32'(u[0].pops - base), 32'd16);

    // Reset in the middle of a data bit.
    base = u[0].pops;
    push_byte(0, 8'hA1);
    wait_tx_low(0, 20);
    repeat (12) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_tx", 32'(u[0].tx), 32'd1);
    check("midrst_busy", 32'(u[0].busy), 32'd0);
    check("midrst_rd", 32'(u[0].rd_en), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("postrst_idle", 32'(u[0].busy), 32'd0);
    check("postrst_tx", 32'(u[0].tx), 32'd1);
    check("postrst_no_repop", 32'(u[0].pops - base), 32'd1);

    // Even parity on the second instance.
    push_byte(1, 8'h07);
    push_byte(1, 8'h03);
    u[1].en = 1'b1;
    @(negedge clk);
    wait_idle(1, 300);
    check("parity_pops", 32'(u[1].pops), 32'd2);

    repeat (5) @(negedge clk);
    check("exp_q_drained0", 32'(u[0].exp_q.size()), 32'd0);
    check("exp_q_drained1", 32'(u[1].exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
